// File: rtl/priority_pkg.sv
// Shared types and default sizes for the priority request server.
// The DWELL state exists only when DWELL_EN is defined.
package priority_pkg;

    localparam int WIDTH_DEF = 9;
    localparam int IDX_W_DEF = 4;

`ifdef DWELL_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DWELL = 2'd2,
        ST_FIN   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_FIN   = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/prio_select.sv
// Combinational highest-index set-bit selector: one-hot, binary index and any-set flag.
module prio_select
    import priority_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan: the last set bit seen wins, which is the highest index.
    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

    assign any = |pending;

endmodule

// File: rtl/priority_request_server.sv
// Serves a captured request vector highest index first over a valid/ready port.
// Optional feature: define DWELL_EN to insert DWELL_CYCLES idle cycles before each presentation.
module priority_request_server
    import priority_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int IDX_W        = IDX_W_DEF,
    parameter int DWELL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_in,
    input  logic             load,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W-1:0] served_cnt,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sel_onehot;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic             handshake;

`ifdef DWELL_EN
    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    logic [DW_W-1:0] dwell_q, dwell_d;
`endif

    prio_select #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_sel (
        .pending(pending_q),
        .onehot (sel_onehot),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    // Handshake: a request transfers on a rising edge where out_valid and out_ready
    // are both high; while out_valid is high and out_ready low, the presented request holds.
    assign out_valid  = (state_q == ST_SERVE) && sel_any;
    assign handshake  = out_valid && out_ready;
    assign out_onehot = out_valid ? sel_onehot : '0;
    assign out_idx    = out_valid ? sel_idx : '0;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);
    assign served_cnt = cnt_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
`ifdef DWELL_EN
        dwell_d   = dwell_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    pending_d = req_in;
                    cnt_d     = '0;
                    if (req_in == '0) begin
                        state_d = ST_FIN;
                    end else begin
`ifdef DWELL_EN
                        state_d = ST_DWELL;
                        dwell_d = '0;
`else
                        state_d = ST_SERVE;
`endif
                    end
                end
            end
`ifdef DWELL_EN
            ST_DWELL: begin
                if (dwell_q == DW_W'(DWELL_CYCLES - 1)) begin
                    state_d = ST_SERVE;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
`endif
            ST_SERVE: begin
                if (handshake) begin
                    pending_d = pending_q & ~sel_onehot;
                    cnt_d     = cnt_q + IDX_W'(1);
                    if ((pending_q & ~sel_onehot) == '0) begin
                        state_d = ST_FIN;
                    end else begin
`ifdef DWELL_EN
                        state_d = ST_DWELL;
                        dwell_d = '0;
`else
                        state_d = ST_SERVE;
`endif
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            cnt_q     <= '0;
`ifdef DWELL_EN
            dwell_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
`ifdef DWELL_EN
            dwell_q   <= dwell_d;
`endif
        end
    end

endmodule

// File: tb/tb_priority_request_server.sv
// Self-checking bench for priority_request_server: directed batches, scoreboard of served indices.
// Build with DWELL_EN defined to exercise the dwell timing instead of the no-dwell timing.
module tb_priority_request_server;

    localparam int WIDTH = 9;
    localparam int IDX_W = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] req_in;
    logic             load;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_onehot;
    logic [IDX_W-1:0] out_idx;
    logic [IDX_W-1:0] served_cnt;
    logic             done;

    int checks;
    int failures;

    logic [IDX_W-1:0] exp_q[$];
    logic [IDX_W-1:0] exp_done_q[$];

    priority_request_server #(
        .WIDTH       (WIDTH),
        .IDX_W       (IDX_W),
        .DWELL_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .load      (load),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_onehot(out_onehot),
        .out_idx   (out_idx),
        .served_cnt(served_cnt),
        .done      (done)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Driver tasks
    task automatic push_expected(input logic [WIDTH-1:0] req);
        logic [IDX_W-1:0] n;
        n = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                exp_q.push_back(IDX_W'(i));
                n++;
            end
        end
        exp_done_q.push_back(n);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] req);
        @(posedge clk);
        #1;
        req_in = req;
        load   = 1'b1;
        push_expected(req);
        @(posedge clk);
        #1;
        load   = 1'b0;
        req_in = '0;
    endtask

    task automatic wait_idle(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_handshake", {28'd0, out_idx}, 32'hFFFF_FFFF);
            end else begin
                automatic logic [IDX_W-1:0] e = exp_q.pop_front();
                automatic logic [WIDTH-1:0] oh = '0;
                oh[e] = 1'b1;
                check("served_idx", {28'd0, out_idx}, {28'd0, e});
                check("served_onehot", {23'd0, out_onehot}, {23'd0, oh});
            end
        end
        if (!out_valid) begin
            check("idle_outputs_zero", {19'd0, out_onehot, out_idx}, 32'd0);
        end
        if (done) begin
            check("done_busy", {31'd0, busy}, 32'd1);
            if (exp_done_q.size() == 0) begin
                check("unexpected_done", {28'd0, served_cnt}, 32'hFFFF_FFFF);
            end else begin
                automatic logic [IDX_W-1:0] c = exp_done_q.pop_front();
                check("done_served_cnt", {28'd0, served_cnt}, {28'd0, c});
            end
        end
    end

    // Stimulus
    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        load      = 1'b0;
        req_in    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {busy, out_valid, done, out_onehot, out_idx, served_cnt},
              32'd0);
        #1 rst_n = 1'b1;

`ifndef DWELL_EN
        // Three requests served back to back with ready held high.
        out_ready = 1'b1;
        do_load(9'b100100001);
        @(negedge clk);
        check("seq_c1_idx", {27'd0, out_valid, out_idx}, {27'd0, 1'b1, 4'd8});
        @(negedge clk);
        check("seq_c2_idx", {27'd0, out_valid, out_idx}, {27'd0, 1'b1, 4'd5});
        @(negedge clk);
        check("seq_c3_idx", {27'd0, out_valid, out_idx}, {27'd0, 1'b1, 4'd0});
        @(negedge clk);
        check("seq_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("seq_final", {27'd0, busy, served_cnt}, {27'd0, 1'b0, 4'd3});
`else
        // Dwell: four quiet cycles before each presentation.
        out_ready = 1'b1;
        do_load(9'b000010001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("dwell1_wait", {30'd0, busy, out_valid}, {30'd0, 2'b10});
        end
        @(negedge clk);
        check("dwell1_idx", {27'd0, out_valid, out_idx}, {27'd0, 1'b1, 4'd4});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("dwell2_wait", {30'd0, busy, out_valid}, {30'd0, 2'b10});
        end
        @(negedge clk);
        check("dwell2_idx", {27'd0, out_valid, out_idx}, {27'd0, 1'b1, 4'd0});
        wait_idle("dwell_idle");
        check("dwell_final_cnt", {28'd0, served_cnt}, 32'd2);
`endif

        // Zero-request batch completes immediately.
        do_load('0);
        @(negedge clk);
        check("zero_done", {30'd0, done, out_valid}, {30'd0, 2'b10});
        @(negedge clk);
        check("zero_final", {27'd0, busy, served_cnt}, 32'd0);

        // Backpressure: the presentation holds while ready is low.
        out_ready = 1'b0;
        do_load(9'b000001010);
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_idx", {28'd0, out_idx}, 32'd3);
            check("bp_hold_onehot", {23'd0, out_onehot}, {23'd0, 9'b000001000});
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle("bp_idle");
        check("bp_final_cnt", {28'd0, served_cnt}, 32'd2);

        // Loads while busy are ignored.
        do_load(9'b000100010);
        load   = 1'b1;
        req_in = 9'h0F0;
        @(posedge clk);
        @(posedge clk);
        #1;
        load   = 1'b0;
        req_in = '0;
        wait_idle("ignore_idle");
        check("ignore_final_cnt", {28'd0, served_cnt}, 32'd2);

        // Reset mid-batch, then a clean restart.
        do_load(9'h1FF);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (served_cnt == 4'd1) break;
        end
        check("mid_cnt_one", {28'd0, served_cnt}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs", {busy, out_valid, done, out_onehot, out_idx, served_cnt},
              32'd0);
        exp_q.delete();
        exp_done_q.delete();
        rst_n = 1'b1;
        do_load(9'b000000100);
        wait_idle("restart_idle");
        check("restart_cnt", {28'd0, served_cnt}, 32'd1);

        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("exp_done_q_empty", exp_done_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
